// File: rtl/yc_line_sequencer.sv
// Per-line sequencer feeding the Y/C separator: hsync timing, blank level, pixel strobes.
// Optional back-porch blank capture enabled by defining YC_SEQ_BLANK_CAPTURE_EN.
module yc_line_sequencer #(
  parameter int DATA_WIDTH   = 12,
  parameter int WINDOW_SIZE  = 32,
  parameter int BP_START     = 16,
  parameter int ACTIVE_START = 64,
  parameter int ACTIVE_LEN   = 640,
  parameter int VALID_DELAY  = 18,
  parameter int BLANK_LEVEL  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] adc_in,
  input  logic                         hsync_in,
  output logic signed [DATA_WIDTH-1:0] sep_data_out,
  output logic signed [DATA_WIDTH-1:0] blank_level_out,
  output logic                         yc_valid_out,
  output logic [15:0]                  pix_x_out,
  output logic                         line_start_out,
  output logic                         line_err_out
);

  localparam int HW        = WINDOW_SIZE / 2;
  localparam int BLANK_LEN = ACTIVE_START - HW;
  localparam int AW        = DATA_WIDTH + 4;

  if (ACTIVE_START < BP_START + 16 + HW) begin : g_bad_timing
    $error("ACTIVE_START too small for blank capture and window");
  end

  typedef enum logic [2:0] {
    IDLE,
    BLANK,
    FEED,
    ACTIVE,
    TAIL
  } state_t;

  state_t      state_q;
  state_t      cur_state;
  state_t      state_n;
  logic [15:0] seg_q;
  logic [15:0] cur_seg;
  logic [15:0] seg_n;
  logic [15:0] h_cnt;
  logic [15:0] idx;
  logic        hsync_q;
  logic        hs_edge;
  logic        err_w;
  logic        feed_w;
  logic        ent_v;
  logic [15:0] ent_pix;

  // seg counts samples left in the current phase, so the
  // phase walk is independent of h_cnt saturation
  always_comb begin
    hs_edge   = hsync_in & ~hsync_q;
    idx       = hs_edge ? 16'd0 : h_cnt;
    cur_state = hs_edge ? BLANK : state_q;
    cur_seg   = hs_edge ? 16'(BLANK_LEN - 1) : seg_q;
    err_w     = hs_edge && (state_q != IDLE);
    state_n   = cur_state;
    seg_n     = cur_seg - 16'd1;
    if (cur_state == IDLE) begin
      seg_n = '0;
    end else if (cur_seg == 16'd0) begin
      unique case (cur_state)
        BLANK: begin
          state_n = FEED;
          seg_n   = 16'(HW - 1);
        end
        FEED: begin
          state_n = ACTIVE;
          seg_n   = 16'(ACTIVE_LEN - 1);
        end
        ACTIVE: begin
          state_n = TAIL;
          seg_n   = 16'(HW - 1);
        end
        default: begin
          state_n = IDLE;
          seg_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    feed_w  = (cur_state == FEED) ||
              (cur_state == ACTIVE) ||
              (cur_state == TAIL);
    ent_v   = (cur_state == ACTIVE);
    ent_pix = 16'(ACTIVE_LEN - 1) - cur_seg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      seg_q          <= '0;
      h_cnt          <= '0;
      hsync_q        <= 1'b0;
      sep_data_out   <= '0;
      line_start_out <= 1'b0;
      line_err_out   <= 1'b0;
    end else begin
      state_q        <= state_n;
      seg_q          <= seg_n;
      h_cnt          <= (idx == 16'hFFFF) ? idx : idx + 16'd1;
      hsync_q        <= hsync_in;
      sep_data_out   <= feed_w ? adc_in : blank_level_out;
      line_start_out <= hs_edge;
      line_err_out   <= err_w;
    end
  end

  logic [VALID_DELAY-1:0] vq;
  logic [VALID_DELAY:0]   vch;
  logic [15:0]            pq  [VALID_DELAY];
  logic [15:0]            pch [VALID_DELAY+1];

  always_comb begin
    vch    = {vq, ent_v};
    pch[0] = ent_pix;
    for (int i = 0; i < VALID_DELAY; i++) begin
      pch[i+1] = pq[i];
    end
  end

  // last pixel stage only loads on a valid entry so the
  // index holds between active pixels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vq <= '0;
      for (int i = 0; i < VALID_DELAY; i++) begin
        pq[i] <= '0;
      end
    end else begin
      if (err_w) begin
        vq <= '0;
      end else begin
        vq <= vch[VALID_DELAY-1:0];
      end
      for (int i = 0; i < VALID_DELAY - 1; i++) begin
        pq[i] <= pch[i];
      end
      if (vch[VALID_DELAY-1] && !err_w) begin
        pq[VALID_DELAY-1] <= pch[VALID_DELAY-1];
      end
    end
  end

  assign yc_valid_out = vq[VALID_DELAY-1];
  assign pix_x_out    = pq[VALID_DELAY-1];

`ifdef YC_SEQ_BLANK_CAPTURE_EN
  logic signed [AW-1:0]         acc_q;
  logic signed [AW-1:0]         acc_base;
  logic signed [AW-1:0]         acc_add;
  logic signed [DATA_WIDTH-1:0] blank_q;
  logic                         run_w;
  logic                         bp_hit;

  always_comb begin
    run_w    = (cur_state != IDLE);
    bp_hit   = run_w &&
               (idx >= 16'(BP_START)) &&
               (idx <= 16'(BP_START + 15));
    acc_base = (idx == 16'd0) ? '0 : acc_q;
    acc_add  = bp_hit ? {{4{adc_in[DATA_WIDTH-1]}}, adc_in} : '0;
  end

  // average lands one sample after the last back-porch sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      blank_q <= DATA_WIDTH'(BLANK_LEVEL);
    end else begin
      if (run_w) begin
        acc_q <= acc_base + acc_add;
      end
      if (run_w && (idx == 16'(BP_START + 16))) begin
        blank_q <= acc_q[AW-1:4];
      end
    end
  end

  assign blank_level_out = blank_q;
`else
  assign blank_level_out = DATA_WIDTH'(BLANK_LEVEL);
`endif

endmodule

// File: tb/tb_yc_line_sequencer.sv
// Directed bench for yc_line_sequencer at default parameters.
// Expectations follow the capture build when YC_SEQ_BLANK_CAPTURE_EN is defined.
module tb_yc_line_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [11:0] adc_in;
  logic               hsync_in;
  logic signed [11:0] sep_data_out;
  logic signed [11:0] blank_level_out;
  logic               yc_valid_out;
  logic [15:0]        pix_x_out;
  logic               line_start_out;
  logic               line_err_out;

  int checks   = 0;
  int failures = 0;
  logic signed [11:0] blank_m = 12'sd0;

  yc_line_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .adc_in          (adc_in),
    .hsync_in        (hsync_in),
    .sep_data_out    (sep_data_out),
    .blank_level_out (blank_level_out),
    .yc_valid_out    (yc_valid_out),
    .pix_x_out       (pix_x_out),
    .line_start_out  (line_start_out),
    .line_err_out    (line_err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step(input logic signed [11:0] a,
                      input logic h);
    adc_in   = a;
    hsync_in = h;
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input int len,
                          input logic signed [11:0] bpv,
                          input bit err0);
    int nv = 0;
    int ns = 0;
    int c;
    logic signed [11:0] a;
    logic signed [11:0] es;
    for (int i = 0; i < len; i++) begin
      a = (i >= 16 && i < 32) ? bpv : 12'(i);
      step(a, i < 4);
      es = (i >= 48 && i <= 719) ? a : blank_m;
`ifdef YC_SEQ_BLANK_CAPTURE_EN
      if (i == 32) blank_m = bpv;
`endif
      c = i + 1;
      chk("sep", 32'(sep_data_out), 32'(es));
      chk("blank", 32'(blank_level_out), 32'(blank_m));
      chk("valid", 32'(yc_valid_out),
          32'(c >= 82 && c <= 721));
      if (c >= 82 && c <= 721)
        chk("pix", 32'(pix_x_out), 32'(c - 82));
      chk("lstart", 32'(line_start_out), 32'(i == 0));
      chk("lerr", 32'(line_err_out), 32'(i == 0 && err0));
      if (yc_valid_out) nv++;
      if (line_start_out) ns++;
    end
    chk("nstart", 32'(ns), 32'd1);
    if (len >= 722) chk("nvalid", 32'(nv), 32'd640);
  endtask

  task automatic idle(input int n, input logic [15:0] pix);
    for (int i = 0; i < n; i++) begin
      step(12'(i + 5), 1'b0);
      chk("idle_sep", 32'(sep_data_out), 32'(blank_m));
      chk("idle_valid", 32'(yc_valid_out), 32'd0);
      chk("idle_pix", 32'(pix_x_out), 32'(pix));
      chk("idle_lstart", 32'(line_start_out), 32'd0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    adc_in   = '0;
    hsync_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sep", 32'(sep_data_out), 32'd0);
    chk("rst_blank", 32'(blank_level_out), 32'd0);
    chk("rst_valid", 32'(yc_valid_out), 32'd0);
    chk("rst_pix", 32'(pix_x_out), 32'd0);
    chk("rst_lstart", 32'(line_start_out), 32'd0);
    chk("rst_lerr", 32'(line_err_out), 32'd0);
    rst = 1'b0;
    idle(5, 16'd0);

    run_line(740, -12'sd200, 1'b0);
    idle(10, 16'd639);

    run_line(25, 12'sd500, 1'b0);
    run_line(300, 12'sd2047, 1'b1);
    run_line(740, -12'sd2048, 1'b1);
    idle(10, 16'd639);

    run_line(100, 12'sd300, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    blank_m = 12'sd0;
    chk("mid_rst_sep", 32'(sep_data_out), 32'd0);
    chk("mid_rst_blank", 32'(blank_level_out), 32'd0);
    chk("mid_rst_valid", 32'(yc_valid_out), 32'd0);
    chk("mid_rst_pix", 32'(pix_x_out), 32'd0);
    chk("mid_rst_lstart", 32'(line_start_out), 32'd0);
    chk("mid_rst_lerr", 32'(line_err_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(120, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/yc_line_sequencer.md
Name: yc_line_sequencer

Overview:
- Per-line controller for the Y/C separator datapath; sits between the video ADC sample stream and the separator input.
- Tracks horizontal timing from hsync and captures the back-porch blanking level.
- Feeds the separator blanking level outside video, real samples only around the active region, so the sliding window never straddles sync tips.
- Generates a pixel-valid strobe and pixel index aligned to the separator's luma/chroma outputs.

Parameters:
DATA_WIDTH, 12, sample width (signed two's complement)
WINDOW_SIZE, 32, separator window length; power of two, >= 4
BP_START, 16, first back-porch sample index used for blank capture (16 samples captured)
ACTIVE_START, 64, sample index of first active pixel; must be >= BP_START+16+WINDOW_SIZE/2
ACTIVE_LEN, 640, active pixels per line, 1..65535
VALID_DELAY, 18, cycles from an active sample on adc_in to its yc_valid_out; >= 1
BLANK_LEVEL, 0, fixed blank level used when blank capture is compiled out

Ports:
clk  in  1  sample clock
rst  in  1  asynchronous, active-high reset
adc_in  in  DATA_WIDTH  signed ADC sample, one per clock
hsync_in  in  1  synchronous to clk; rising edge marks line start
sep_data_out  out  DATA_WIDTH  signed sample to separator data_in (registered)
blank_level_out  out  DATA_WIDTH  current blanking level
yc_valid_out  out  1  separator outputs carry an active pixel this cycle
pix_x_out  out  16  pixel index (0..ACTIVE_LEN-1) qualified by yc_valid_out
line_start_out  out  1  one-cycle pulse on each accepted hsync edge
line_err_out  out  1  one-cycle pulse when hsync edge arrives mid-line

Behaviour:
- Reset (async, active-high): all outputs 0; blank_level_out = BLANK_LEVEL; state IDLE; counters, capture sum, hsync history and valid pipeline cleared.
- Edge detect: edge = hsync_in & ~hsync_q. The edge cycle is sample index 0; a 16-bit h_cnt tracks the index of adc_in in every later cycle.
- States, with sample index ranges relative to the edge:
  - IDLE: waiting for an edge.
  - BLANK: indices 0..ACTIVE_START-WINDOW_SIZE/2-1.
  - FEED: next WINDOW_SIZE/2 samples.
  - ACTIVE: ACTIVE_LEN samples.
  - TAIL: next WINDOW_SIZE/2 samples.
  - After TAIL the FSM returns to IDLE.
- Edge in IDLE: go to BLANK; pulse line_start_out.
- Edge in BLANK/FEED/ACTIVE/TAIL:
  - Restart at BLANK (index 0).
  - Pulse line_start_out and line_err_out.
  - Clear every in-flight valid bit; yc_valid_out is low from the next cycle.
- sep_data_out, registered, 1-cycle latency:
  - Previous-cycle adc_in when that sample was in FEED/ACTIVE/TAIL.
  - Otherwise blank_level_out.
- Blank capture:
  - Sum samples at indices BP_START..BP_START+15 into a DATA_WIDTH+4-bit signed accumulator, cleared at index 0.
  - After index BP_START+15, blank_level_out <= sum >>> 4 (arithmetic shift, truncated), effective the next cycle.
  - If the line aborts before capture completes, blank_level_out holds its old value.
- Valid pipeline:
  - VALID_DELAY-deep shift register of {valid, 16-bit pixel index}, entered with valid=1 for each ACTIVE sample.
  - yc_valid_out and pix_x_out are the pipeline output (registered).
  - pix_x_out holds its last value when not valid.
- Line without edge: after TAIL the FSM sits in IDLE indefinitely.
- h_cnt saturates at 16'hFFFF.

Optional Feature:
- Macro: YC_SEQ_BLANK_CAPTURE_EN.
- Defined: back-porch capture as above.
- Undefined: no accumulator; blank_level_out is the constant BLANK_LEVEL; BP_START is ignored.
- All other behaviour is identical in both builds.

Test Plan:
- Reset mid-line (rst asserted at index 100): all outputs 0 immediately; after release with no edge, sep_data_out stays BLANK_LEVEL (0).
- Defaults, adc_in=-200 at indices 16..31, else ramp: blank_level_out=-200 from index 33; sep_data_out=-200 until it shows sample 48 (one cycle after adc_in carries sample 48).
- Defaults, one full line: yc_valid_out high for exactly 640 consecutive cycles, first at 18 cycles after sample 64; pix_x_out runs 0..639; line_start_out is one pulse.
- Edge at index 300 (mid-ACTIVE): line_err_out pulses once; yc_valid_out low from next cycle; new line yields 640 valids with pix_x_out restarting at 0.
- Back-porch samples +2047 x16 (capture enabled): blank_level_out=2047, no overflow; samples -2048 x16 give -2048.
- Build without YC_SEQ_BLANK_CAPTURE_EN, BLANK_LEVEL=-300: blank_level_out=-300 constantly; samples 0..47 appear on sep_data_out as -300.
